// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing the single-port data_ram between the load/store
// unit (master 0) and a DMA/debug master (master 1), with bounded bus locking.
module data_ram_arbiter #(
  parameter int DEPTH_NUM_BITS_WIDTH = 7,
  parameter int LOCK_MAX             = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        ram_w_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {S_OPEN, S_LOCK0, S_LOCK1} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_last, w_last_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]      r_addr, r_wdata;
  logic             r_rvalid0, r_rvalid1, r_err0, r_err1;
  logic [31:0]      r_rdata0, r_rdata1;

  logic             w_gnt0, w_gnt1, w_any_gnt;
  logic             w_win_we, w_win_lock, w_in_range;
  logic [31:0]      w_win_addr, w_win_wdata, w_rsp_data;

  // State register: arbitration state, round-robin pointer, lock counter.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_OPEN;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    if (w_any_gnt) w_last_nxt = w_gnt1;
    case (r_state)
      S_OPEN: begin
        if (w_any_gnt && w_win_lock && (LOCK_MAX > 1)) begin
          w_state_nxt = w_gnt1 ? S_LOCK1 : S_LOCK0;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_LOCK0: begin
        if (!m0_req || !m0_lock || (r_cnt >= CNT_LAST)) begin
          w_state_nxt = S_OPEN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_LOCK1: begin
        if (!m1_req || !m1_lock || (r_cnt >= CNT_LAST)) begin
          w_state_nxt = S_OPEN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_OPEN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Grant logic; the owner of a lock is the only master that can win.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      case (r_state)
        S_OPEN: begin
          if (m0_req && m1_req) begin
            w_gnt0 = r_last;
            w_gnt1 = !r_last;
          end else begin
            w_gnt0 = m0_req;
            w_gnt1 = m1_req;
          end
        end
        S_LOCK0: w_gnt0 = m0_req;
        S_LOCK1: w_gnt1 = m1_req;
        default: ;
      endcase
    end
  end

  assign w_any_gnt   = w_gnt0 | w_gnt1;
  assign w_win_we    = w_gnt1 ? m1_we    : m0_we;
  assign w_win_lock  = w_gnt1 ? m1_lock  : m0_lock;
  assign w_win_addr  = w_gnt1 ? m1_addr  : m0_addr;
  assign w_win_wdata = w_gnt1 ? m1_wdata : m0_wdata;
  assign w_in_range  = (w_win_addr[31:DEPTH_NUM_BITS_WIDTH] == '0);
  // Writes and out-of-range accesses both answer with zero data.
  assign w_rsp_data  = (w_win_we || !w_in_range) ? 32'd0 : ram_rdata;

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign ram_w_en  = w_any_gnt & w_win_we & w_in_range;
  assign ram_addr  = w_any_gnt ? w_win_addr  : r_addr;
  assign ram_wdata = w_any_gnt ? w_win_wdata : r_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_gnt0;
      r_rvalid1 <= w_gnt1;
      if (w_any_gnt) begin
        r_addr  <= w_win_addr;
        r_wdata <= w_win_wdata;
      end
      if (w_gnt0) begin
        r_rdata0 <= w_rsp_data;
        r_err0   <= !w_in_range;
      end
      if (w_gnt1) begin
        r_rdata1 <= w_rsp_data;
        r_err1   <= !w_in_range;
      end
    end
  end

  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign m0_err    = r_err0;
  assign m1_err    = r_err1;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a small behavioral data_ram
// (combinational read, write on the clock edge) attached to the RAM port.
module tb_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_w_en;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_w_en) mem[ram_addr[6:2]] <= ram_wdata;
  assign ram_rdata = mem[ram_addr[6:2]];

  data_ram_arbiter #(.DEPTH_NUM_BITS_WIDTH(7), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_w_en(ram_w_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_write(input logic [31:0] a, input logic [31:0] d);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = a; m0_wdata = d;
    step();
    m0_req = 1'b0; m0_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    step(); step();

    // Reset state, with requests forced off while rst is high.
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hFFFF_FFFF; m1_req = 1;
    #1;
    check("rst_gnt0", m0_gnt, 0);
    check("rst_gnt1", m1_gnt, 0);
    check("rst_wen", ram_w_en, 0);
    check("rst_rvalid0", m0_rvalid, 0);
    check("rst_rvalid1", m1_rvalid, 0);
    check("rst_rdata0", m0_rdata, 0);
    check("rst_err1", m1_err, 0);
    check("rst_addr", ram_addr, 0);
    m0_req = 0; m0_we = 0; m1_req = 0; rst = 0;
    step();

    m0_write(32'h00, 32'h1111_1111);
    m0_write(32'h04, 32'h4444_4444);
    m0_write(32'h14, 32'hCAFE_F00D);
    m0_write(32'h20, 32'h2020_2020);

    // Uncontended write then read.
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF;
    #1;
    check("wr_gnt0", m0_gnt, 1);
    check("wr_wen", ram_w_en, 1);
    check("wr_addr", ram_addr, 32'h10);
    step();
    m0_we = 0;
    #1;
    check("wr_rvalid0", m0_rvalid, 1);
    check("wr_rdata0", m0_rdata, 0);
    check("rd_gnt0", m0_gnt, 1);
    step();
    m0_req = 0;
    #1;
    check("rd_rvalid0", m0_rvalid, 1);
    check("rd_rdata0", m0_rdata, 32'hDEAD_BEEF);
    check("rd_err0", m0_err, 0);
    step();
    check("rd_pulse0", m0_rvalid, 0);

    // Round-robin contention from reset.
    rst = 1;
    step();
    rst = 0;
    check("rr_rst_rdata0", m0_rdata, 0);
    for (int i = 0; i < 6; i++) begin
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      m1_req = 1; m1_we = 0; m1_addr = 32'h14;
      #1;
      check($sformatf("rr_gnt0_%0d", i), m0_gnt, (i % 2 == 0));
      check($sformatf("rr_gnt1_%0d", i), m1_gnt, (i % 2 == 1));
      if (i > 0) begin
        if (i % 2 == 1) begin
          check($sformatf("rr_rv0_%0d", i), m0_rvalid, 1);
          check($sformatf("rr_rd0_%0d", i), m0_rdata, 32'hDEAD_BEEF);
        end else begin
          check($sformatf("rr_rv1_%0d", i), m1_rvalid, 1);
          check($sformatf("rr_rd1_%0d", i), m1_rdata, 32'hCAFE_F00D);
        end
      end
      step();
    end
    m0_req = 0; m1_req = 0;
    #1;
    check("rr_rv1_last", m1_rvalid, 1);
    check("rr_rd1_last", m1_rdata, 32'hCAFE_F00D);
    step();

    // Locked read-modify-write by master 1.
    m1_req = 1; m1_we = 0; m1_addr = 32'h20; m1_lock = 1;
    #1;
    check("lk_gnt1_a", m1_gnt, 1);
    step();
    m1_we = 1; m1_wdata = 32'h5A5A_1234; m1_lock = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    #1;
    check("lk_gnt0_b", m0_gnt, 0);
    check("lk_gnt1_b", m1_gnt, 1);
    check("lk_rd1_b", m1_rdata, 32'h2020_2020);
    step();
    m1_req = 0; m1_we = 0;
    #1;
    check("lk_gnt0_c", m0_gnt, 1);
    check("lk_rv1_c", m1_rvalid, 1);
    check("lk_rd1_c", m1_rdata, 0);
    step();
    m0_req = 0;
    #1;
    check("lk_rv0_d", m0_rvalid, 1);
    check("lk_rd0_d", m0_rdata, 32'h5A5A_1234);
    step();

    // Lock timeout after 4 grants (LOCK_MAX=4).
    m0_req = 1; m0_we = 0; m0_addr = 32'h00; m0_lock = 1;
    #1;
    check("to_gnt0_0", m0_gnt, 1);
    step();
    m1_req = 1; m1_we = 0; m1_addr = 32'h04;
    for (int k = 1; k < 4; k++) begin
      #1;
      check($sformatf("to_gnt0_%0d", k), m0_gnt, 1);
      check($sformatf("to_gnt1_%0d", k), m1_gnt, 0);
      check($sformatf("to_rd0_%0d", k), m0_rdata, 32'h1111_1111);
      step();
    end
    #1;
    check("to_gnt1_4", m1_gnt, 1);
    check("to_gnt0_4", m0_gnt, 0);
    step();
    m0_req = 0; m0_lock = 0; m1_req = 0;
    #1;
    check("to_rv1_5", m1_rvalid, 1);
    check("to_rd1_5", m1_rdata, 32'h4444_4444);
    check("to_rv0_5", m0_rvalid, 0);
    step();

    // Out-of-range write is suppressed and flagged.
    m1_req = 1; m1_we = 1; m1_addr = 32'h80; m1_wdata = 32'h55;
    #1;
    check("oor_gnt1", m1_gnt, 1);
    check("oor_wen", ram_w_en, 0);
    step();
    m1_req = 0; m1_we = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h00;
    #1;
    check("oor_rv1", m1_rvalid, 1);
    check("oor_err1", m1_err, 1);
    check("oor_rd1", m1_rdata, 0);
    check("oor_gnt0", m0_gnt, 1);
    step();
    m0_req = 0;
    #1;
    check("oor_word0", m0_rdata, 32'h1111_1111);
    check("oor_err0", m0_err, 0);
    step();

    // Reset in LOCK1 with a read response pending.
    m1_req = 1; m1_we = 0; m1_addr = 32'h20; m1_lock = 1;
    #1;
    check("rl_gnt1_a", m1_gnt, 1);
    step();
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    #1;
    check("rl_gnt1_b", m1_gnt, 1);
    check("rl_gnt0_b", m0_gnt, 0);
    step();
    rst = 1; m1_we = 1; m1_wdata = 32'hBADB_AD00;
    #1;
    check("rl_gnt1_rst", m1_gnt, 0);
    check("rl_wen_rst", ram_w_en, 0);
    step();
    rst = 0; m1_we = 0; m1_lock = 0;
    #1;
    check("rl_rv0", m0_rvalid, 0);
    check("rl_rv1", m1_rvalid, 0);
    check("rl_rd1", m1_rdata, 0);
    check("rl_gnt0", m0_gnt, 1);
    check("rl_gnt1", m1_gnt, 0);
    step();
    m0_req = 0; m1_req = 0;
    #1;
    check("rl_rv0_e", m0_rvalid, 1);
    check("rl_rd0_e", m0_rdata, 32'h5A5A_1234);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
